// File: rtl/and_5bit_unit.sv
// and_5bit_unit
// Registered bitwise-AND ALU slice for the 5-bit CPU datapath. Produces
// z = a & b together with the carry/sign/zero flags used by the flag
// register and branch logic. Single-cycle latency, valid-qualified.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        synchronous active-high reset (priority over in_valid)
//   in_valid   a/b carry a new operation this cycle
//   a, b       operands, WIDTH bits
//   out_valid  z/flags were updated by the previous cycle's valid input
//   z          registered a & b
//   cf         carry flag, constant 0 for AND
//   sf         sign flag, z[WIDTH-1]
//   zf         zero flag, z == 0
//   zcnt       saturating count of zero results (AND5_ZCOUNT_EN only)
//
// Build option:
//   AND5_ZCOUNT_EN  when defined, adds the zcnt output and its CNT_W-bit
//                   saturating counter of accepted zero results.

module and_5bit_unit #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] z,
    output logic             cf,
    output logic             sf,
    output logic             zf
`ifdef AND5_ZCOUNT_EN
    ,
    output logic [CNT_W-1:0] zcnt
`endif
);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 2) begin : g_width_chk
        $error("and_5bit_unit: WIDTH must be >= 2");
    end
    if (CNT_W < 1) begin : g_cntw_chk
        $error("and_5bit_unit: CNT_W must be >= 1");
    end

    // Stage p0: combinational result of the operands presented this cycle.
    logic [WIDTH-1:0] w_and_p0;
    logic             w_zero_p0;

    assign w_and_p0  = a & b;
    assign w_zero_p0 = (w_and_p0 == '0);

    // Stage p1: registered result, flags and valid.
    logic [WIDTH-1:0] r_z_p1;
    logic             r_cf_p1;
    logic             r_sf_p1;
    logic             r_zf_p1;
    logic             r_vld_p1;

    // Operands are only sampled when in_valid is high, so unknown a/b on
    // idle cycles never reach the registers. The flags are taken from the
    // same value that is loaded into r_z_p1, keeping them consistent with z.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z_p1   <= '0;
            r_cf_p1  <= 1'b0;
            r_sf_p1  <= 1'b0;
            r_zf_p1  <= 1'b1;
            r_vld_p1 <= 1'b0;
        end else if (in_valid) begin
            r_z_p1   <= w_and_p0;
            r_cf_p1  <= 1'b0;
            r_sf_p1  <= w_and_p0[WIDTH-1];
            r_zf_p1  <= w_zero_p0;
            r_vld_p1 <= 1'b1;
        end else begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign z         = r_z_p1;
    assign cf        = r_cf_p1;
    assign sf        = r_sf_p1;
    assign zf        = r_zf_p1;
    assign out_valid = r_vld_p1;

`ifdef AND5_ZCOUNT_EN
    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 1'b1;
        end
    endfunction

    logic [CNT_W-1:0] r_zcnt_p1;

    // Updated on the same edge as zf, so both become visible together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zcnt_p1 <= '0;
        end else if (in_valid && w_zero_p0) begin
            r_zcnt_p1 <= sat_inc(r_zcnt_p1);
        end
    end

    assign zcnt = r_zcnt_p1;
`endif

endmodule

// File: tb/tb_and_5bit_unit.sv
module tb_and_5bit_unit;
    localparam int WIDTH = 5;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic [WIDTH-1:0] z;
    logic             cf, sf, zf;
`ifdef AND5_ZCOUNT_EN
    logic [CNT_W-1:0] zcnt;
`endif

    and_5bit_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid), .z(z), .cf(cf), .sf(sf), .zf(zf)
`ifdef AND5_ZCOUNT_EN
        , .zcnt(zcnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: what the outputs must show after each edge.
    bit m_ok = 0;
    int m_z, m_vld, m_zcnt;
    localparam int ZMAX = (1 << CNT_W) - 1;
    localparam int SIGN = 1 << (WIDTH - 1);

    always @(posedge clk) begin
        if (rst) begin
            m_ok = 1; m_z = 0; m_vld = 0; m_zcnt = 0;
        end else if (in_valid) begin
            m_z = int'(a) & int'(b);
            m_vld = 1;
            if (m_z == 0 && m_zcnt < ZMAX) m_zcnt = m_zcnt + 1;
        end else begin
            m_vld = 0;
        end
    end

    // Compare on every falling edge once the model is anchored by reset.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("model.out_valid", 32'(out_valid), 32'(m_vld));
            chk("model.z", 32'(z), 32'(m_z));
            chk("model.cf", 32'(cf), 32'd0);
            chk("model.sf", 32'(sf), 32'(m_z >= SIGN));
            chk("model.zf", 32'(zf), 32'(m_z == 0));
`ifdef AND5_ZCOUNT_EN
            chk("model.zcnt", 32'(zcnt), 32'(m_zcnt));
`endif
        end
    end

    task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv);
        rst = r; in_valid = v; a = av; b = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input int ez, input int ev, input int esf, input int ezf);
        chk({nm, ".z"}, 32'(z), 32'(ez));
        chk({nm, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({nm, ".sf"}, 32'(sf), 32'(esf));
        chk({nm, ".zf"}, 32'(zf), 32'(ezf));
        chk({nm, ".cf"}, 32'(cf), 32'd0);
    endtask

    initial begin
        @(posedge clk); #1;
        // Reset held two cycles while valid, all-ones operands are presented.
        step(1, 1, 5'b11111, 5'b11111);
        step(1, 1, 5'b11111, 5'b11111);
        lit("reset", 0, 0, 0, 1);
        // Basic AND.
        step(0, 1, 5'b10101, 5'b01100);
        lit("basic", 5'b00100, 1, 0, 0);
        // Back-to-back zero results.
        step(0, 1, 5'b11100, 5'b00000);
        lit("zero1", 0, 1, 0, 1);
        step(0, 1, 5'b00000, 5'b00000);
        lit("zero2", 0, 1, 0, 1);
        // Sign, then idle with changed operands: hold.
        step(0, 1, 5'b11111, 5'b10000);
        lit("sign", 5'b10000, 1, 1, 0);
        step(0, 0, 5'b00011, 5'b00111);
        lit("hold", 5'b10000, 0, 1, 0);
        // Idle with unknown operands must not disturb the held result.
        step(0, 0, 'x, 'x);
        lit("hold_x", 5'b10000, 0, 1, 0);
        // Reset wins over a valid input in the same cycle.
        step(1, 1, 5'b11111, 5'b11111);
        lit("rst_prio", 0, 0, 0, 1);
`ifdef AND5_ZCOUNT_EN
        step(0, 1, 5'b00000, 5'b00101);
        chk("zcnt.1", 32'(zcnt), 32'd1);
        step(0, 1, 5'b00011, 5'b00100);
        chk("zcnt.2", 32'(zcnt), 32'd2);
        step(0, 1, 5'b00001, 5'b00010);
        chk("zcnt.3", 32'(zcnt), 32'd3);
        step(0, 1, 5'b00001, 5'b00001);
        chk("zcnt.nz", 32'(zcnt), 32'd3);
        step(1, 0, 5'b00000, 5'b00000);
        chk("zcnt.rst", 32'(zcnt), 32'd0);
        for (int i = 0; i < 300; i++) step(0, 1, 5'b00000, 5'(i));
        chk("zcnt.sat", 32'(zcnt), 32'd255);
`endif
        // Randomised traffic with occasional reset.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 5'($urandom), 5'($urandom));
        end
        step(0, 0, 5'b00000, 5'b00000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
